// File: rtl/cannon_shot.sv
// cannon_shot: projectile for a two-player artillery game.
// A shell is launched from the selected tank. It moves once per frame under
// gravity, and the flight ends when the shell hits the opposing tank or leaves
// the playfield.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per frame (advances the shell)
//   fire, shooter            launch request and which player fires
//   power_x, power_y         unsigned horizontal / upward launch speed
//   player_x*/player_y*      tank top-left corners (tanks are 20x16)
//   alive_0, alive_1         player still has health
//   cannon_x, cannon_y       top-left of the 9x9 shell
//   active                   shell in flight
//   hit_0, hit_1, miss       one-cycle result pulses
module cannon_shot #(
  parameter int GRAVITY  = 1,
  parameter int GROUND_Y = 400,
  parameter int OBS_X0   = 300,
  parameter int OBS_X1   = 340,
  parameter int OBS_Y0   = 250,
  parameter int SCREEN_W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       shooter,
  input  logic [3:0] power_x,
  input  logic [3:0] power_y,
  input  logic [9:0] player_x0,
  input  logic [9:0] player_y0,
  input  logic [9:0] player_x1,
  input  logic [9:0] player_y1,
  input  logic       alive_0,
  input  logic       alive_1,
  output logic [9:0] cannon_x,
  output logic [9:0] cannon_y,
  output logic       active,
  output logic       hit_0,
  output logic       hit_1,
  output logic       miss
);

  localparam int unsigned CW = 11;

  localparam int SHELL     = 9;
  localparam int TANK_W    = 20;
  localparam int TANK_H    = 16;
  localparam int MUZZLE_DX = 5;
  localparam int TOP_LIMIT = -64;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLIGHT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]           state, state_n;
  logic signed [CW-1:0] x, y, vx, vy;
  logic signed [CW-1:0] x_n, y_n, vx_n, vy_n;
  logic                 shot_by, shot_by_n;
  logic                 active_n, hit_0_n, hit_1_n, miss_n;

  // Position and velocity after one frame of motion.
  logic signed [CW-1:0] nx, ny, nvy;
  assign nx  = x + vx;
  assign ny  = y + vy;
  assign nvy = vy + CW'(GRAVITY);

  assign cannon_x = x[9:0];
  assign cannon_y = y[9:0];

  // Collision tests on the moved shell, evaluated in int to avoid wrap.
  int   sx, sy, ox, oy;
  logic opp_alive, tank_touch, obs_hit, gnd_hit, off_hit;
  logic hit_now, end_now;

  always_comb begin
    sx        = int'(nx);
    sy        = int'(ny);
    ox        = shot_by ? int'(player_x0) : int'(player_x1);
    oy        = shot_by ? int'(player_y0) : int'(player_y1);
    opp_alive = shot_by ? alive_0 : alive_1;
    // Touching the tank outline counts as a hit.
    tank_touch = (sx <= ox + TANK_W) && (ox <= sx + SHELL) &&
                 (sy <= oy + TANK_H) && (oy <= sy + SHELL);
    obs_hit    = (sx < OBS_X1) && (OBS_X0 < sx + SHELL) &&
                 (sy < GROUND_Y) && (OBS_Y0 < sy + SHELL);
    gnd_hit    = (sy + SHELL > GROUND_Y);
    off_hit    = (sx < 0) || (sx > SCREEN_W - SHELL) || (sy < TOP_LIMIT);
    // A dead opponent cannot be hit; the shot then ends as a miss.
    hit_now    = opp_alive && tank_touch;
    end_now    = hit_now || !opp_alive || obs_hit || gnd_hit || off_hit;
  end

  // Launch values taken from the selected shooter.
  logic                 shooter_alive;
  logic [9:0]           sel_x, sel_y;
  assign shooter_alive = shooter ? alive_1 : alive_0;
  assign sel_x         = shooter ? player_x1 : player_x0;
  assign sel_y         = shooter ? player_y1 : player_y0;

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    vx_n      = vx;
    vy_n      = vy;
    shot_by_n = shot_by;
    active_n  = active;
    hit_0_n   = 1'b0;
    hit_1_n   = 1'b0;
    miss_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire && shooter_alive) begin
          x_n       = $signed(CW'(sel_x)) + CW'(MUZZLE_DX);
          y_n       = $signed(CW'(sel_y)) - CW'(SHELL);
          vx_n      = shooter ? -$signed(CW'(power_x)) : $signed(CW'(power_x));
          vy_n      = -$signed(CW'(power_y));
          shot_by_n = shooter;
          active_n  = 1'b1;
          state_n   = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (frame_tick) begin
          x_n  = nx;
          y_n  = ny;
          vy_n = nvy;
          if (end_now) begin
            state_n  = S_DONE;
            active_n = 1'b0;
            if (hit_now) begin
              hit_0_n = shot_by;
              hit_1_n = !shot_by;
            end else begin
              miss_n = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (frame_tick) state_n = S_IDLE;
      end
      default: begin
        state_n  = S_IDLE;
        active_n = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      vx      <= '0;
      vy      <= '0;
      shot_by <= 1'b0;
      active  <= 1'b0;
      hit_0   <= 1'b0;
      hit_1   <= 1'b0;
      miss    <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      vx      <= vx_n;
      vy      <= vy_n;
      shot_by <= shot_by_n;
      active  <= active_n;
      hit_0   <= hit_0_n;
      hit_1   <= hit_1_n;
      miss    <= miss_n;
    end
  end

endmodule

// File: tb/tb_cannon_shot.sv
// Testbench for cannon_shot: table of launch scenarios with a trajectory
// scoreboard, plus hand-written sequences for reset, busy/dead shooter and
// end-of-flight corner cases.
module tb_cannon_shot;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       fire;
  logic       shooter;
  logic [3:0] power_x;
  logic [3:0] power_y;
  logic [9:0] player_x0, player_y0, player_x1, player_y1;
  logic       alive_0, alive_1;
  logic [9:0] cannon_x, cannon_y;
  logic       active, hit_0, hit_1, miss;

  cannon_shot dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .fire       (fire),
    .shooter    (shooter),
    .power_x    (power_x),
    .power_y    (power_y),
    .player_x0  (player_x0),
    .player_y0  (player_y0),
    .player_x1  (player_x1),
    .player_y1  (player_y1),
    .alive_0    (alive_0),
    .alive_1    (alive_1),
    .cannon_x   (cannon_x),
    .cannon_y   (cannon_y),
    .active     (active),
    .hit_0      (hit_0),
    .hit_1      (hit_1),
    .miss       (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result codes: 0 none, 1 hit_0, 2 hit_1, 3 miss.
  typedef struct {
    logic sh;
    int   p0x, p0y, p1x, p1y;
    int   pwx, pwy;
    int   refire_at;
    int   exp_ticks;
    int   exp_res;
    int   exp_x, exp_y;
  } vec_t;

  typedef struct {
    int x, y, act, h0, h1, ms;
  } sb_t;

  vec_t vt[6];
  sb_t  sbq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference trajectory state.
  int   mx, my, mvx, mvy;
  logic msh;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic setup(input logic sh, input int p0x, input int p0y,
                       input int p1x, input int p1y, input int pwx, input int pwy);
    shooter   = sh;
    player_x0 = 10'(p0x);
    player_y0 = 10'(p0y);
    player_x1 = 10'(p1x);
    player_y1 = 10'(p1y);
    power_x   = 4'(pwx);
    power_y   = 4'(pwy);
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    cyc();
    fire = 1'b0;
  endtask

  // One frame of the reference physics; returns the result code.
  function automatic int model_step();
    int tx, ty;
    logic oal;
    mx  = mx + mvx;
    my  = my + mvy;
    mvy = mvy + 1;
    tx  = msh ? int'(player_x0) : int'(player_x1);
    ty  = msh ? int'(player_y0) : int'(player_y1);
    oal = msh ? alive_0 : alive_1;
    if (!oal) return 3;
    if (mx <= tx + 20 && mx + 9 >= tx && my <= ty + 16 && my + 9 >= ty)
      return msh ? 1 : 2;
    if (mx + 9 > 300 && mx < 340 && my + 9 > 250 && my < 400) return 3;
    if (my + 9 > 400) return 3;
    if (mx < 0 || mx > 631 || my < -64) return 3;
    return 0;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   ticks;
    int   code;
    int   dut_res;
    sb_t  e;
    setup(v.sh, v.p0x, v.p0y, v.p1x, v.p1y, v.pwx, v.pwy);
    alive_0 = 1'b1;
    alive_1 = 1'b1;
    pulse_fire();
    msh = v.sh;
    mx  = (v.sh ? v.p1x : v.p0x) + 5;
    my  = (v.sh ? v.p1y : v.p0y) - 9;
    mvx = v.sh ? -v.pwx : v.pwx;
    mvy = -v.pwy;
    chk($sformatf("v%0d launch_x", idx), int'(cannon_x), mx & 1023);
    chk($sformatf("v%0d launch_y", idx), int'(cannon_y), my & 1023);
    chk($sformatf("v%0d launch_active", idx), int'(active), 1);
    ticks = 0;
    while (active && ticks < 60) begin
      frame_tick = 1'b1;
      if (ticks + 1 == v.refire_at) begin
        fire    = 1'b1;
        shooter = ~v.sh;
        power_x = 4'd15;
        power_y = 4'd15;
      end
      code  = model_step();
      e.x   = mx & 1023;
      e.y   = my & 1023;
      e.act = (code == 0) ? 1 : 0;
      e.h0  = (code == 1) ? 1 : 0;
      e.h1  = (code == 2) ? 1 : 0;
      e.ms  = (code == 3) ? 1 : 0;
      sbq.push_back(e);
      cyc();
      frame_tick = 1'b0;
      fire       = 1'b0;
      ticks++;
      e = sbq.pop_front();
      chk($sformatf("v%0d t%0d x", idx, ticks), int'(cannon_x), e.x);
      chk($sformatf("v%0d t%0d y", idx, ticks), int'(cannon_y), e.y);
      chk($sformatf("v%0d t%0d status", idx, ticks),
          {int'(active), int'(hit_0), int'(hit_1), int'(miss)} == {e.act, e.h0, e.h1, e.ms} ? 1 : 0, 1);
    end
    dut_res = hit_0 ? 1 : hit_1 ? 2 : miss ? 3 : 0;
    chk($sformatf("v%0d ticks", idx), ticks, v.exp_ticks);
    chk($sformatf("v%0d result", idx), dut_res, v.exp_res);
    chk($sformatf("v%0d final_x", idx), int'(cannon_x), v.exp_x & 1023);
    chk($sformatf("v%0d final_y", idx), int'(cannon_y), v.exp_y & 1023);
    cyc();
    chk($sformatf("v%0d pulse_len", idx), int'(hit_0 | hit_1 | miss), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_pulse;
    //          sh    p0x  p0y  p1x  p1y pwx pwy rf tk res   ex   ey
    vt[0] = '{1'b0, 100, 384, 500, 384,  0,  0, 0, 7, 3,  105, 396};
    vt[1] = '{1'b0, 280, 384, 290, 384,  5,  0, 0, 1, 2,  290, 375};
    vt[2] = '{1'b0, 200, 384, 600, 384, 15,  8, 0, 6, 3,  295, 342};
    vt[3] = '{1'b1, 600, 384,  10, 384, 15,  2, 0, 2, 3,  -15, 372};
    vt[4] = '{1'b1, 180, 384, 200, 384,  5,  0, 0, 1, 1,  200, 375};
    vt[5] = '{1'b0, 100, 384, 500, 384,  0,  0, 3, 7, 3,  105, 396};

    rst = 1'b1; frame_tick = 1'b0; fire = 1'b0;
    alive_0 = 1'b1; alive_1 = 1'b1;
    setup(1'b0, 100, 384, 500, 384, 0, 0);
    @(negedge clk);
    cyc();
    chk("reset cannon_x", int'(cannon_x), 0);
    chk("reset cannon_y", int'(cannon_y), 0);
    chk("reset active", int'(active), 0);
    chk("reset pulses", int'(hit_0 | hit_1 | miss), 0);

    // Fire during reset is ignored.
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    rst  = 1'b0;
    chk("fire_in_reset active", int'(active), 0);
    cyc();
    chk("fire_in_reset after", int'(active), 0);

    // Dead shooter cannot fire.
    alive_0 = 1'b0;
    pulse_fire();
    chk("dead_shooter active", int'(active), 0);
    tick();
    chk("dead_shooter after_tick", int'(active), 0);
    alive_0 = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // fire together with frame_tick in IDLE launches without moving.
    setup(1'b0, 100, 384, 500, 384, 0, 3);
    fire = 1'b1; frame_tick = 1'b1;
    cyc();
    fire = 1'b0; frame_tick = 1'b0;
    chk("fire_with_tick active", int'(active), 1);
    chk("fire_with_tick y", int'(cannon_y), 375);
    rst = 1'b1; cyc(); rst = 1'b0;

    // Reset mid-flight aborts with no result pulse.
    setup(1'b0, 100, 384, 500, 384, 0, 0);
    pulse_fire();
    tick();
    chk("rst_mid t1 y", int'(cannon_y), 375);
    tick();
    chk("rst_mid t2 y", int'(cannon_y), 376);
    rst = 1'b1; frame_tick = 1'b1;
    cyc();
    rst = 1'b0; frame_tick = 1'b0;
    chk("rst_mid outputs", int'({active, hit_0, hit_1, miss, cannon_x, cannon_y}), 0);
    any_pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_pulse = any_pulse | hit_0 | hit_1 | miss | active;
    end
    chk("rst_mid no_pulse", int'(any_pulse), 0);
    pulse_fire();
    chk("rst_mid idle_refire y", int'(cannon_y), 375);
    rst = 1'b1; cyc(); rst = 1'b0;

    // Opponent dies mid-flight: next tick is a miss.
    setup(1'b0, 100, 384, 500, 384, 0, 0);
    pulse_fire();
    tick();
    alive_1 = 1'b0;
    tick();
    chk("opp_dead miss", int'(miss), 1);
    chk("opp_dead hit_1", int'(hit_1), 0);
    chk("opp_dead active", int'(active), 0);
    alive_1 = 1'b1;

    // DONE ignores fire and waits for a frame_tick; no queued launch.
    pulse_fire();
    chk("done_fire active", int'(active), 0);
    tick();
    cyc();
    chk("done_no_queue active", int'(active), 0);
    pulse_fire();
    chk("done_then_fire active", int'(active), 1);
    rst = 1'b1; cyc(); rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cannon_shot.md
CANNON_SHOT -- requirements
Module: cannon_shot

Interface
REQ-001 SHALL have parameter GRAVITY, default 1, meaning the vertical velocity increment applied per frame.
REQ-002 SHALL have parameter GROUND_Y, default 400, meaning the first row of ground.
REQ-003 SHALL have parameter OBS_X0, default 300, meaning the obstacle's left column (inclusive).
REQ-004 SHALL have parameter OBS_X1, default 340, meaning the obstacle's right column (exclusive).
REQ-005 SHALL have parameter OBS_Y0, default 250, meaning the obstacle's top row.
REQ-006 SHALL have parameter SCREEN_W, default 640, meaning the visible width in pixels.
REQ-007 SHALL have port clk, input, 1 bit: pixel-domain clock; the only clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per frame.
REQ-010 SHALL have port fire, input, 1 bit: one-cycle request to launch a shot.
REQ-011 SHALL have port shooter, input, 1 bit: 0 = player0 fires toward +x; 1 = player1 fires toward -x.
REQ-012 SHALL have port power_x, input, 4 bits: unsigned horizontal launch speed.
REQ-013 SHALL have port power_y, input, 4 bits: unsigned upward launch speed.
REQ-014 SHALL have ports player_x0, player_y0, player_x1, player_y1, input, 10 bits each: tank top-left corners; each tank is 20 wide by 16 tall.
REQ-015 SHALL have ports alive_0 and alive_1, input, 1 bit each: the player's health is nonzero.
REQ-016 SHALL have ports cannon_x and cannon_y, output, 10 bits each: top-left of the 9x9 shell, in the renderer's coordinates.
REQ-017 SHALL have port active, output, 1 bit: shell in flight; the renderer draws the shell only while this is high.
REQ-018 SHALL have ports hit_0 and hit_1, output, 1 bit each: one-cycle pulse when the shell strikes that player.
REQ-019 SHALL have port miss, output, 1 bit: one-cycle pulse when the shell ends without a hit.

Function
REQ-020 SHALL implement the states IDLE, FLIGHT and DONE in a registered state machine.
REQ-021 SHALL, in IDLE, accept fire only if the selected shooter is alive; otherwise fire SHALL be ignored.
REQ-022 SHALL, on an accepted fire, load the following on the next edge and enter FLIGHT:
- x = shooter x + 5;
- y = shooter y - 9;
- vx = +power_x if shooter = 0, or -power_x if shooter = 1;
- vy = -power_y.
REQ-023 SHALL ignore fire while in FLIGHT or DONE; no queueing.
REQ-024 SHALL hold internal x, y, vx and vy as 11-bit signed values; cannon_x and cannon_y SHALL be the low 10 bits of x and y.
REQ-025 SHALL, on each frame_tick in FLIGHT, update within that one cycle: x += vx, y += vy, vy += GRAVITY.
REQ-026 SHALL check collisions combinationally on the updated position, in this priority order:
- the opponent's tank box overlaps the shell box -> hit;
- the shell box overlaps the obstacle [OBS_X0,OBS_X1) x [OBS_Y0,GROUND_Y) -> miss;
- y + 9 > GROUND_Y -> miss;
- x < 0, x > SCREEN_W - 9, or y < -64 -> miss.
REQ-027 SHALL never score a hit on the shooter's own tank.
REQ-028 SHALL, when any REQ-026 condition is true, enter DONE and pulse exactly one of hit_0, hit_1 or miss for one clk cycle on entry to DONE.
REQ-029 SHALL drop active in the same cycle the result pulse is asserted.
REQ-030 SHALL return from DONE to IDLE on the next frame_tick.
REQ-031 SHALL treat frame_tick as a no-op in IDLE; fire and frame_tick arriving together in IDLE SHALL take the fire.
REQ-032 SHALL ignore changes to the player_* inputs during flight, except as targets of the collision test.
REQ-033 SHALL end the flight with a miss on the next frame_tick if the opponent's alive input drops mid-flight.

Reset
REQ-034 SHALL, while rst is high at a clk edge, force the state machine to IDLE.
REQ-035 SHALL, while rst is high at a clk edge, zero x, y, vx, vy, cannon_x, cannon_y, active, hit_0, hit_1 and miss.
REQ-036 SHALL abort any flight on reset mid-flight with no result pulse.
REQ-037 SHALL ignore fire in the cycle in which rst is high.

Verification
REQ-038 SHALL cover a vertical drop: shooter 0 at (100,384), power 0/0, fire.
- Required: y on successive ticks is 375, 376, 378, 381, 385, 390, 396.
- Required: miss pulses on tick 7 and x stays 105.
REQ-039 SHALL cover a direct hit: shooter 0 at (280,384), player1 at (290,384), power_x 5, power_y 0, fire.
- Required: hit_1 pulses on tick 1 (x = 290); hit_0 and miss stay 0.
REQ-040 SHALL cover the obstacle: shooter 0 at (200,384), power_x 15, power_y 8, player1 at (600,384).
- Required: miss on the tick where x first reaches 292 or more inside the obstacle rows; active drops in the same cycle.
REQ-041 SHALL cover busy and dead shooters:
- fire while in FLIGHT -> trajectory unchanged;
- fire with alive_0 = 0 and shooter = 0 -> stays IDLE, active = 0.
REQ-042 SHALL cover reset mid-flight: rst high at tick 3 -> next cycle all outputs are 0, state is IDLE, and no hit or miss pulse occurs.
REQ-043 SHALL cover off-screen exit: shooter 1 at (10,384), power_x 15, power_y 2 -> miss once x < 0; no wrap to 1023 appears on cannon_x while active.
